eth_pcs_tx_seq: RTL and testbench
=================================

Name: eth_pcs_tx_seq

Overview:
Transmit-side sequencer for the 10GBASE-R PCS 64b/66b encoder. It generates the encoder's per-transfer clock enable and transfer index, and inserts the gearbox pause that absorbs sync-header overhead on the fixed-width serial interface. It also runs a start-up phase of forced idle blocks, and gives the MAC a per-transfer ready so XGMII words are only presented when the encoder accepts them.

Parameters:
N_TRANS_PER_BLK, 2, XGMII transfers per 64-bit block (W_DATA = 64/N_TRANS_PER_BLK)
W_TRANS_PER_BLK, 1, width of the transfer index, $clog2(N_TRANS_PER_BLK), minimum 1
BLKS_PER_SEQ, 32, blocks between gearbox pauses
PAUSE_CYCLES, 2, clock-enable-low cycles per gearbox pause
INIT_BLKS, 16, forced-idle blocks sent after enable, before MAC traffic

Ports:
i_clk  in  1  PCS TX clock
i_reset_n  in  1  asynchronous active-low reset
i_enable  in  1  PCS TX enable from management, level
o_clk_en  out  1  encoder/gearbox clock enable
o_trans_cnt  out  W_TRANS_PER_BLK  transfer index within block, to encoder
o_blk_start  out  1  o_clk_en & (o_trans_cnt == 0)
o_mac_ready  out  1  MAC must present a valid XGMII transfer this cycle
o_force_idle  out  1  XGMII mux selects /I/ on all channels instead of MAC data
o_seq_cnt  out  $clog2(BLKS_PER_SEQ)  block index within gearbox sequence
o_running  out  1  state == RUN

Behaviour:
- Interface is fixed: one clock, i_clk; reset is asynchronous and active-low, i_reset_n.
- Reset values, applied asynchronously: state IDLE, o_clk_en 0, o_trans_cnt 0, o_seq_cnt 0, o_blk_start 0, o_mac_ready 0, o_force_idle 1, o_running 0, init counter 0.
- States: IDLE, INIT, RUN, PAUSE. All outputs are registered. PAUSE stores its return state, INIT or RUN.
- IDLE: o_clk_en 0; all counters held at 0. If i_enable=1, the next state is INIT.
- INIT and RUN: o_clk_en 1 every cycle. o_trans_cnt increments each cycle and wraps from N_TRANS_PER_BLK-1 to 0.
- Block boundary = cycle with o_clk_en=1 and o_trans_cnt=N_TRANS_PER_BLK-1. At each boundary, o_seq_cnt increments, wrapping from BLKS_PER_SEQ-1 to 0.
- A boundary with o_seq_cnt=BLKS_PER_SEQ-1 enters PAUSE for exactly PAUSE_CYCLES cycles. During PAUSE: o_clk_en 0, o_trans_cnt 0, o_mac_ready 0, o_seq_cnt 0. PAUSE then returns to its saved state, or to RUN if the INIT count completed on the same boundary.
- INIT: o_force_idle 1, o_mac_ready 0. The init counter increments at each boundary. The boundary completing block INIT_BLKS-1 transitions to RUN, through PAUSE if that boundary also ends the sequence.
- RUN: o_force_idle 0. o_mac_ready = o_clk_en, so the MAC sees ready and the encoder sees enable on the same cycle.
- Deassert of i_enable in INIT or RUN takes effect only at the next block boundary, so no partial block is sent. That boundary goes to IDLE; PAUSE is skipped and counters clear.
- Deassert of i_enable in PAUSE goes to IDLE on the next cycle.
- Reassert of i_enable always restarts INIT from init count 0.
- Gearbox pause has priority over INIT-to-RUN: RUN is entered only after the pause ends.
- Latency: state and counters update one cycle after the qualifying event. There is no combinational path from i_enable to outputs.
- Long-term enable ratio: N_TRANS_PER_BLK*BLKS_PER_SEQ enabled cycles per (N_TRANS_PER_BLK*BLKS_PER_SEQ + PAUSE_CYCLES) cycles. With defaults, 64 of every 66.

Optional Feature:
- ETH_PCS_TX_SEQ_STATS_EN defined adds two outputs:
  - o_blk_total, 32 bits: counts RUN-state block boundaries, saturates at 32'hFFFF_FFFF, cleared only by i_reset_n.
  - o_pause_total, 16 bits: counts PAUSE entries from any state, wraps.
- Without the macro, neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- Release i_reset_n with i_enable=1 -> IDLE 1 cycle, then 32 enabled cycles with o_force_idle=1 and o_mac_ready=0. The first o_mac_ready=1 is on the 33rd enabled cycle, with o_trans_cnt=0 and o_blk_start=1.
- Steady RUN for 660 cycles -> exactly 640 cycles with o_clk_en=1. Each low pair directly follows o_seq_cnt=31/o_trans_cnt=1. o_trans_cnt alternates 0,1 with no skips.
- Drop i_enable when o_trans_cnt=0 in RUN -> one more enabled cycle at o_trans_cnt=1, then o_clk_en=0, o_running=0, o_seq_cnt=0. Reassert -> 16 INIT blocks again.
- Drop i_enable during the first PAUSE cycle -> IDLE on the next cycle, no further o_clk_en pulses.
- Assert i_reset_n=0 mid-RUN at o_seq_cnt=17, between clock edges -> all outputs take reset values immediately, without a clock edge.
- With ETH_PCS_TX_SEQ_STATS_EN, run 100 RUN blocks -> o_blk_total=100. Pause count = floor((16+100)/32) = 3 PAUSE entries; o_pause_total=3.

Source files
------------

// File: rtl/eth_pcs_tx_seq.sv
// eth_pcs_tx_seq: 10GBASE-R PCS TX sequencer (clock enable, gearbox pause, init idles).
// Optional block/pause statistics outputs when ETH_PCS_TX_SEQ_STATS_EN is defined.
module eth_pcs_tx_seq #(
    parameter int N_TRANS_PER_BLK = 2,
    parameter int W_TRANS_PER_BLK = 1,
    parameter int BLKS_PER_SEQ    = 32,
    parameter int PAUSE_CYCLES    = 2,
    parameter int INIT_BLKS       = 16,
    parameter int W_SEQ_CNT       = $clog2(BLKS_PER_SEQ)
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    output logic                       o_clk_en,
    output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
    output logic                       o_blk_start,
    output logic                       o_mac_ready,
    output logic                       o_force_idle,
    output logic [W_SEQ_CNT-1:0]       o_seq_cnt,
`ifdef ETH_PCS_TX_SEQ_STATS_EN
    output logic                       o_running,
    output logic [31:0]                o_blk_total,
    output logic [15:0]                o_pause_total
`else
    output logic                       o_running
`endif
);

    localparam int W_INIT  = $clog2(INIT_BLKS + 1);
    localparam int W_PAUSE = $clog2(PAUSE_CYCLES + 1);

    localparam logic [W_TRANS_PER_BLK-1:0] TRANS_LAST =
        W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);
    localparam logic [W_SEQ_CNT-1:0] SEQ_LAST =
        W_SEQ_CNT'(BLKS_PER_SEQ - 1);
    localparam logic [W_INIT-1:0] INIT_LAST =
        W_INIT'(INIT_BLKS - 1);
    localparam logic [W_PAUSE-1:0] PAUSE_LAST =
        W_PAUSE'(PAUSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, PAUSE} state_t;

    state_t                     state, state_d;
    state_t                     ret_state, ret_d;
    logic [W_INIT-1:0]          init_cnt, init_d;
    logic [W_PAUSE-1:0]         pause_cnt, pause_d;
    logic [W_TRANS_PER_BLK-1:0] trans_d;
    logic [W_SEQ_CNT-1:0]       seq_d;
    logic                       clk_en_d;
    logic                       blk_start_d;
    logic                       mac_ready_d;
    logic                       force_idle_d;
    logic                       running_d;
    logic                       boundary;

    assign boundary = o_clk_en && (o_trans_cnt == TRANS_LAST);

    // State, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            ret_state    <= INIT;
            init_cnt     <= '0;
            pause_cnt    <= '0;
            o_clk_en     <= 1'b0;
            o_trans_cnt  <= '0;
            o_seq_cnt    <= '0;
            o_blk_start  <= 1'b0;
            o_mac_ready  <= 1'b0;
            o_force_idle <= 1'b1;
            o_running    <= 1'b0;
        end else begin
            state        <= state_d;
            ret_state    <= ret_d;
            init_cnt     <= init_d;
            pause_cnt    <= pause_d;
            o_clk_en     <= clk_en_d;
            o_trans_cnt  <= trans_d;
            o_seq_cnt    <= seq_d;
            o_blk_start  <= blk_start_d;
            o_mac_ready  <= mac_ready_d;
            o_force_idle <= force_idle_d;
            o_running    <= running_d;
        end
    end

    // Next state plus counter updates; disable at a boundary beats the pause
    always_comb begin
        state_d = state;
        ret_d   = ret_state;
        init_d  = init_cnt;
        pause_d = pause_cnt;
        trans_d = '0;
        seq_d   = '0;
        unique case (state)
            IDLE: begin
                init_d = '0;
                if (i_enable) state_d = INIT;
            end
            INIT, RUN: begin
                trans_d = boundary ? '0 : o_trans_cnt + 1'b1;
                seq_d   = o_seq_cnt;
                if (boundary) begin
                    seq_d = (o_seq_cnt == SEQ_LAST) ? '0 : o_seq_cnt + 1'b1;
                    if (!i_enable) begin
                        state_d = IDLE;
                        seq_d   = '0;
                        init_d  = '0;
                    end else begin
                        ret_d = state;
                        if (state == INIT) begin
                            init_d = init_cnt + 1'b1;
                            if (init_cnt == INIT_LAST) begin
                                state_d = RUN;
                                ret_d   = RUN;
                            end
                        end
                        if (o_seq_cnt == SEQ_LAST) begin
                            state_d = PAUSE;
                            pause_d = '0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (pause_cnt == PAUSE_LAST) begin
                    state_d = ret_state;
                end else begin
                    pause_d = pause_cnt + 1'b1;
                end
            end
        endcase
    end

    // Output values for the upcoming state
    always_comb begin
        clk_en_d     = (state_d == INIT) || (state_d == RUN);
        mac_ready_d  = (state_d == RUN);
        running_d    = (state_d == RUN);
        force_idle_d = !((state_d == RUN) ||
                         ((state_d == PAUSE) && (ret_d == RUN)));
        blk_start_d  = clk_en_d && (trans_d == '0);
    end

`ifdef ETH_PCS_TX_SEQ_STATS_EN
    // RUN block count (saturating) and pause entry count (wrapping)
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_blk_total   <= '0;
            o_pause_total <= '0;
        end else begin
            if ((state == RUN) && boundary && (o_blk_total != 32'hFFFF_FFFF))
                o_blk_total <= o_blk_total + 32'd1;
            if ((state_d == PAUSE) && (state != PAUSE))
                o_pause_total <= o_pause_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_pcs_tx_seq.sv
// tb_eth_pcs_tx_seq: directed checks of init phase, gearbox pauses,
// enable drop handling and asynchronous reset for eth_pcs_tx_seq.
module tb_eth_pcs_tx_seq;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       clk_en;
    logic [0:0] trans_cnt;
    logic       blk_start;
    logic       mac_ready;
    logic       force_idle;
    logic [4:0] seq_cnt;
    logic       running;
`ifdef ETH_PCS_TX_SEQ_STATS_EN
    logic [31:0] blk_total;
    logic [15:0] pause_total;
`endif

    int errors = 0;
    int checks = 0;

    eth_pcs_tx_seq dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_enable     (enable),
        .o_clk_en     (clk_en),
        .o_trans_cnt  (trans_cnt),
        .o_blk_start  (blk_start),
        .o_mac_ready  (mac_ready),
        .o_force_idle (force_idle),
        .o_seq_cnt    (seq_cnt),
`ifdef ETH_PCS_TX_SEQ_STATS_EN
        .o_running    (running),
        .o_blk_total  (blk_total),
        .o_pause_total(pause_total)
`else
        .o_running    (running)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts forced-idle enabled cycles until the first MAC ready
    task automatic run_init(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (mac_ready) begin
                ok = 1'b1;
                break;
            end
            if (clk_en && force_idle) n++;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_clk_en"}, 32'(clk_en), 0);
        check({pfx, "_trans"}, 32'(trans_cnt), 0);
        check({pfx, "_seq"}, 32'(seq_cnt), 0);
        check({pfx, "_blk_start"}, 32'(blk_start), 0);
        check({pfx, "_mac_ready"}, 32'(mac_ready), 0);
        check({pfx, "_force_idle"}, 32'(force_idle), 1);
        check({pfx, "_running"}, 32'(running), 0);
    endtask

    initial begin
        int  n;
        bit  ok;
        int  en_cnt, pauses, bad_pause, bad_tr, bad_rdy, bad_seq, lowrun;
        int  pulses, blks;
        bit  prev_en;
        logic [0:0] prev_tr;
        logic [4:0] prev_seq;

        rst_n  = 1'b0;
        enable = 1'b1;
        #12;
        check_reset_vals("rst0");
`ifdef ETH_PCS_TX_SEQ_STATS_EN
        check("rst0_blk_total", blk_total, 0);
        check("rst0_pause_total", 32'(pause_total), 0);
`endif

        // Start-up: 16 idle blocks then MAC traffic
        @(negedge clk);
        rst_n = 1'b1;
        run_init(n, ok);
        check("init1_done", 32'(ok), 1);
        check("init1_cycles", n, 32);
        check("init1_trans", 32'(trans_cnt), 0);
        check("init1_blk_start", 32'(blk_start), 1);
        check("init1_force_idle", 32'(force_idle), 0);
        check("init1_seq", 32'(seq_cnt), 16);

        // Steady RUN over ten full gearbox sequences
        en_cnt = 0; pauses = 0; bad_pause = 0; bad_tr = 0;
        bad_rdy = 0; bad_seq = 0; lowrun = 0;
        prev_en = 1'b1; prev_tr = 1'b1; prev_seq = 5'd15;
        for (int i = 0; i < 660; i++) begin
            if (clk_en) en_cnt++;
            if (!clk_en && prev_en) begin
                pauses++;
                if (!(prev_seq == 5'd31 && prev_tr == 1'b1)) bad_pause++;
            end
            if (!clk_en) lowrun++;
            if (clk_en && !prev_en) begin
                if (lowrun != 2) bad_pause++;
                lowrun = 0;
                if (trans_cnt != 1'b0) bad_tr++;
            end
            if (clk_en && prev_en && trans_cnt != ~prev_tr) bad_tr++;
            if (mac_ready != clk_en) bad_rdy++;
            if (!clk_en && seq_cnt != 5'd0) bad_seq++;
            prev_en  = clk_en;
            prev_tr  = trans_cnt;
            prev_seq = seq_cnt;
            tick();
        end
        check("run_en_cycles", en_cnt, 640);
        check("run_pauses", pauses, 10);
        check("run_bad_pause", bad_pause, 0);
        check("run_bad_trans", bad_tr, 0);
        check("run_bad_ready", bad_rdy, 0);
        check("run_bad_seq", bad_seq, 0);

        // Drop enable mid-block: finish the block, then IDLE
        check("drop_pre_trans", 32'(trans_cnt), 0);
        check("drop_pre_running", 32'(running), 1);
        enable = 1'b0;
        tick();
        check("drop_last_en", 32'(clk_en), 1);
        check("drop_last_trans", 32'(trans_cnt), 1);
        tick();
        check("drop_clk_en", 32'(clk_en), 0);
        check("drop_running", 32'(running), 0);
        check("drop_seq", 32'(seq_cnt), 0);
        check("drop_force_idle", 32'(force_idle), 1);
        tick();
        tick();
        check("drop_idle_hold", 32'(clk_en), 0);

        // Reassert: full init phase again
        enable = 1'b1;
        run_init(n, ok);
        check("init2_done", 32'(ok), 1);
        check("init2_cycles", n, 32);
        check("init2_seq", 32'(seq_cnt), 16);

        // Drop enable in the first pause cycle
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!clk_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("pause_found", 32'(ok), 1);
        check("pause_running", 32'(running), 0);
        check("pause_force_idle", 32'(force_idle), 0);
        enable = 1'b0;
        tick();
        check("pdrop_clk_en", 32'(clk_en), 0);
        check("pdrop_force_idle", 32'(force_idle), 1);
        check("pdrop_seq", 32'(seq_cnt), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clk_en) pulses++;
        end
        check("pdrop_no_pulses", pulses, 0);

        // Async reset between edges mid-RUN
        enable = 1'b1;
        run_init(n, ok);
        check("init3_cycles", n, 32);
        tick();
        tick();
        check("arst_pre_seq", 32'(seq_cnt), 17);
        check("arst_pre_en", 32'(clk_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");

        // Restart from reset and, with stats, count blocks and pauses
        @(negedge clk);
        rst_n = 1'b1;
        run_init(n, ok);
        check("init4_cycles", n, 32);
        blks = 0;
        ok   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (running && clk_en && trans_cnt == 1'b1) blks++;
            if (blks == 100) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("stats_blocks_seen", 32'(ok), 1);
        tick();
`ifdef ETH_PCS_TX_SEQ_STATS_EN
        check("stats_blk_total", blk_total, 100);
        check("stats_pause_total", 32'(pause_total), 3);
`endif
        check("stats_running", 32'(running), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
